fc_layer_par: RTL

Parametrised fully-connected layer engine: computes `out[n] = act(sat((bias[n] + Σ x[j]·w[n][j]) >>> shift))` for all OUT_SIZE neurons. It evaluates PAR neurons concurrently over IN_SIZE cycles per group, so PAR selects the area/latency trade-off. It supports runtime-selectable ReLU, requantising right shift and saturation with a sticky flag. It replaces the fixed single-configuration FC layer in the inference datapath and keeps the flattened vector/matrix port style.

---
 rtl/fc_pkg.sv | 29 ++
 rtl/fc_mac_lane.sv | 54 +++++
 rtl/fc_layer_par.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared types and helpers for the parallel fully-connected layer engine:
// FSM state encoding, accumulator width rule and output saturation.
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        WB   = 2'd2
    } fc_state_t;

    // Smallest accumulator that holds IN_SIZE full-width products plus a bias.
    function automatic int acc_width_min(input int w, input int in_size);
        return 2 * w + $clog2(in_size) + 1;
    endfunction

    // Clamp a sign-extended value to the signed range of a w-bit result.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] value, input int w);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (w - 1));
        if (value > max_v)
            return max_v;
        if (value < min_v)
            return min_v;
        return value;
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One neuron lane: signed multiply-accumulate plus the write-back path
// (bias add, arithmetic shift, optional ReLU, saturation with clip flag).
module fc_mac_lane
    import fc_pkg::*;
#(
    parameter int W         = 8,
    parameter int ACC_WIDTH = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 mac_en,
    input  logic signed [W-1:0]  x,
    input  logic signed [W-1:0]  w,
    input  logic signed [W-1:0]  bias,
    input  logic [4:0]           shift,
    input  logic                 relu_en,
    output logic [W-1:0]         result,
    output logic                 clip
);

    localparam int VW = ACC_WIDTH + 1;

    logic signed [2*W-1:0]       prod;
    logic signed [ACC_WIDTH-1:0] acc_reg;
    logic signed [VW-1:0]        v_sum;
    logic signed [VW-1:0]        v_shift;
    logic signed [VW-1:0]        v_relu;
    logic signed [63:0]          v_wide;
    logic signed [63:0]          v_sat;

    assign prod = x * w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            acc_reg <= '0;
        else if (clr)
            acc_reg <= '0;
        else if (mac_en)
            acc_reg <= acc_reg + {{(ACC_WIDTH-2*W){prod[2*W-1]}}, prod};
    end

    // One extra bit of headroom so the bias add can never wrap.
    always_comb begin
        v_sum   = {acc_reg[ACC_WIDTH-1], acc_reg} + {{(VW-W){bias[W-1]}}, bias};
        v_shift = v_sum >>> shift;
        v_relu  = (relu_en && v_shift[VW-1]) ? '0 : v_shift;
        v_wide  = 64'(v_relu);
        v_sat   = sat_w(v_wide, W);
        result  = v_sat[W-1:0];
        clip    = (v_sat != v_wide);
    end

endmodule

// File: rtl/fc_layer_par.sv
// Fully-connected layer: PAR lanes evaluate one group of neurons per IN_SIZE
// MAC cycles, then a write-back cycle stores the group's requantised results.
module fc_layer_par
    import fc_pkg::*;
#(
    parameter int IN_SIZE   = 64,
    parameter int OUT_SIZE  = 8,
    parameter int PAR       = 4,
    parameter int W         = 8,
    parameter int ACC_WIDTH = acc_width_min(W, IN_SIZE)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         relu_en,
    input  logic [4:0]                   shift,
    input  logic [W*IN_SIZE-1:0]         in_vector_flat,
    input  logic [W*OUT_SIZE*IN_SIZE-1:0] weights_flat,
    input  logic [W*OUT_SIZE-1:0]        biases_flat,
    output logic [W*OUT_SIZE-1:0]        out_vector_flat,
    output logic                         busy,
    output logic                         done,
    output logic                         sat_flag
);

    localparam int G  = OUT_SIZE / PAR;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int JW = $clog2(IN_SIZE);

    generate
        if (ACC_WIDTH < acc_width_min(W, IN_SIZE) || ACC_WIDTH > 63) begin : g_bad_acc
            $error("fc_layer_par: ACC_WIDTH out of range");
        end
        if (PAR < 1 || PAR > OUT_SIZE || (OUT_SIZE % PAR) != 0 || IN_SIZE < 2) begin : g_bad_geom
            $error("fc_layer_par: invalid IN_SIZE/OUT_SIZE/PAR combination");
        end
    endgenerate

    fc_state_t                    state_reg, state_next;
    logic [GW-1:0]                g_reg;
    logic [JW-1:0]                j_reg;
    logic [W*IN_SIZE-1:0]         x_snap_reg;
    logic [W*OUT_SIZE*IN_SIZE-1:0] w_snap_reg;
    logic [W*OUT_SIZE-1:0]        b_snap_reg;
    logic                         relu_reg;
    logic [4:0]                   shift_reg;
    logic [W*OUT_SIZE-1:0]        out_reg;
    logic                         done_reg;
    logic                         sat_reg;

    logic                         accept, clr, mac_en, wb, last_group, last_j;
    logic [W-1:0]                 x_cur;
    logic [W-1:0]                 lane_res [PAR];
    logic [PAR-1:0]               lane_clip;

    assign last_group = (g_reg == GW'(G - 1));
    assign last_j     = (j_reg == JW'(IN_SIZE - 1));
    assign x_cur      = x_snap_reg[int'(j_reg)*W +: W];

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        clr        = 1'b0;
        mac_en     = 1'b0;
        wb         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    clr        = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (last_j)
                    state_next = WB;
            end
            WB: begin
                wb         = 1'b1;
                clr        = 1'b1;
                state_next = last_group ? IDLE : MAC;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            g_reg      <= '0;
            j_reg      <= '0;
            x_snap_reg <= '0;
            w_snap_reg <= '0;
            b_snap_reg <= '0;
            relu_reg   <= 1'b0;
            shift_reg  <= '0;
            out_reg    <= '0;
            done_reg   <= 1'b0;
            sat_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= wb && last_group;
            if (accept) begin
                x_snap_reg <= in_vector_flat;
                w_snap_reg <= weights_flat;
                b_snap_reg <= biases_flat;
                relu_reg   <= relu_en;
                shift_reg  <= shift;
                g_reg      <= '0;
                j_reg      <= '0;
                sat_reg    <= 1'b0;
            end
            // j wraps to 0 on the last MAC so the next group starts clean.
            if (mac_en)
                j_reg <= last_j ? '0 : j_reg + 1'b1;
            if (wb) begin
                for (int p = 0; p < PAR; p++)
                    out_reg[(int'(g_reg)*PAR + p)*W +: W] <= lane_res[p];
                sat_reg <= sat_reg | (|lane_clip);
                if (!last_group)
                    g_reg <= g_reg + 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < PAR; gi++) begin : g_lane
            fc_mac_lane #(
                .W         (W),
                .ACC_WIDTH (ACC_WIDTH)
            ) u_lane (
                .clk     (clk),
                .reset   (reset),
                .clr     (clr),
                .mac_en  (mac_en),
                .x       (x_cur),
                .w       (w_snap_reg[((int'(g_reg)*PAR + gi)*IN_SIZE + int'(j_reg))*W +: W]),
                .bias    (b_snap_reg[(int'(g_reg)*PAR + gi)*W +: W]),
                .shift   (shift_reg),
                .relu_en (relu_reg),
                .result  (lane_res[gi]),
                .clip    (lane_clip[gi])
            );
        end
    endgenerate

    assign out_vector_flat = out_reg;
    assign busy            = (state_reg != IDLE);
    assign done            = done_reg;
    assign sat_flag        = sat_reg;

endmodule
